// File: rtl/pwm_duty_ctrl.sv
// Button-driven duty controller: tick-sampled debounce, inc/dec arbitration, clamped duty.
// Optional auto-repeat while a button is held: define PWM_DUTY_AUTOREPEAT_EN.
module pwm_duty_ctrl #(
  parameter int TICK_DIV     = 4,
  parameter int DUTY_MIN     = 1,
  parameter int DUTY_MAX     = 9,
  parameter int DUTY_RST     = 5,
  parameter int REPEAT_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_btn,
  input  logic       dec_btn,
  output logic [3:0] duty,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       at_max,
  output logic       at_min
);

  // state    | meaning
  // IDLE     | no debounced button, next press steps once
  // HOLD_INC | increase held, waiting for release (or repeating)
  // HOLD_DEC | decrease held, waiting for release (or repeating)
  // LOCK     | both held, no steps until both released
  typedef enum logic [1:0] {IDLE, HOLD_INC, HOLD_DEC, LOCK} state_t;

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0] D_MIN = 4'(DUTY_MIN);
  localparam logic [3:0] D_MAX = 4'(DUTY_MAX);
  localparam logic [3:0] D_RST = 4'(DUTY_RST);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [1:0]    inc_s, dec_s;
  logic          inc_db, dec_db;
  logic          can_inc, can_dec;
  state_t        state;

`ifdef PWM_DUTY_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rpt_cnt;
`endif

  assign tick    = (tick_cnt == TICK_LAST);
  assign inc_db  = &inc_s;
  assign dec_db  = &dec_s;
  assign can_inc = (duty < D_MAX);
  assign can_dec = (duty > D_MIN);
  assign at_max  = (duty == D_MAX);
  assign at_min  = (duty == D_MIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      inc_s    <= 2'b00;
      dec_s    <= 2'b00;
    end else if (tick) begin
      tick_cnt <= '0;
      inc_s    <= {inc_s[0], inc_btn};
      dec_s    <= {dec_s[0], dec_btn};
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // FSM sees the debounced levels from before this tick's sample shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      duty      <= D_RST;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
`ifdef PWM_DUTY_AUTOREPEAT_EN
      rpt_cnt   <= '0;
`endif
    end else begin
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (inc_db && dec_db) begin
              state <= LOCK;
            end else if (inc_db) begin
              state <= HOLD_INC;
`ifdef PWM_DUTY_AUTOREPEAT_EN
              rpt_cnt <= '0;
`endif
              if (can_inc) begin
                duty      <= duty + 4'd1;
                inc_pulse <= 1'b1;
              end
            end else if (dec_db) begin
              state <= HOLD_DEC;
`ifdef PWM_DUTY_AUTOREPEAT_EN
              rpt_cnt <= '0;
`endif
              if (can_dec) begin
                duty      <= duty - 4'd1;
                dec_pulse <= 1'b1;
              end
            end
          end
          HOLD_INC: begin
            if (!inc_db) state <= IDLE;
            else if (dec_db) state <= LOCK;
`ifdef PWM_DUTY_AUTOREPEAT_EN
            else if (rpt_cnt == RPT_LAST) begin
              rpt_cnt <= '0;
              if (can_inc) begin
                duty      <= duty + 4'd1;
                inc_pulse <= 1'b1;
              end
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
`endif
          end
          HOLD_DEC: begin
            if (!dec_db) state <= IDLE;
            else if (inc_db) state <= LOCK;
`ifdef PWM_DUTY_AUTOREPEAT_EN
            else if (rpt_cnt == RPT_LAST) begin
              rpt_cnt <= '0;
              if (can_dec) begin
                duty      <= duty - 4'd1;
                dec_pulse <= 1'b1;
              end
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
`endif
          end
          LOCK: begin
            if (!inc_db && !dec_db) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Scoreboard bench for pwm_duty_ctrl: tick-level reference model pushes expected steps,
// a negedge monitor pops them against the DUT strobes and tracks duty/at_max/at_min.
module tb_pwm_duty_ctrl;
  localparam int TD   = 4;
  localparam int DMIN = 1;
  localparam int DMAX = 9;
  localparam int DRST = 5;
  localparam int RPT  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc_btn = 1'b0;
  logic       dec_btn = 1'b0;
  logic [3:0] duty;
  logic       inc_pulse, dec_pulse, at_max, at_min;

  pwm_duty_ctrl #(
    .TICK_DIV(TD), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .DUTY_RST(DRST), .REPEAT_TICKS(RPT)
  ) dut (
    .clk(clk), .rst(rst), .inc_btn(inc_btn), .dec_btn(dec_btn), .duty(duty),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .at_max(at_max), .at_min(at_min)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic up; logic [3:0] duty;} ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // model state: mode 0 idle, 1 inc held, -1 dec held, 2 both held
  int m_duty = DRST;
  int m_mode = 0;
  int m_held = 0;
  int m_cyc  = 0;
  int inc_run = 0;
  int dec_run = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(int dir);
    ev_t e;
    if (dir > 0 && m_duty < DMAX) begin
      m_duty++;
      e.up = 1'b1; e.duty = 4'(m_duty);
      exp_q.push_back(e);
    end else if (dir < 0 && m_duty > DMIN) begin
      m_duty--;
      e.up = 1'b0; e.duty = 4'(m_duty);
      exp_q.push_back(e);
    end
  endtask

  task automatic model_tick(bit ib, bit db);
    bit i, d;
    i = (inc_run >= 2);
    d = (dec_run >= 2);
    inc_run = ib ? inc_run + 1 : 0;
    dec_run = db ? dec_run + 1 : 0;
    if (m_mode == 2) begin
      if (!i && !d) m_mode = 0;
    end else if (i && d) begin
      m_mode = 2;
    end else if (m_mode == 0) begin
      if (i)      begin model_step(1);  m_mode = 1;  m_held = 0; end
      else if (d) begin model_step(-1); m_mode = -1; m_held = 0; end
    end else if ((m_mode == 1 && !i) || (m_mode == -1 && !d)) begin
      m_mode = 0;
    end else begin
`ifdef PWM_DUTY_AUTOREPEAT_EN
      m_held++;
      if (m_held == RPT) begin
        m_held = 0;
        model_step(m_mode);
      end
`endif
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_duty = DRST; m_mode = 0; m_held = 0; m_cyc = 0;
        inc_run = 0; dec_run = 0;
        exp_q.delete();
      end else begin
        if (m_cyc % TD == TD - 1) model_tick(inc_btn, dec_btn);
        m_cyc++;
      end
    end
  end

  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      chk("duty", duty, m_duty);
      chk("at_max", at_max, m_duty == DMAX);
      chk("at_min", at_min, m_duty == DMIN);
      if (inc_pulse && dec_pulse) begin
        chk("both_pulses", 1, 0);
      end else if (inc_pulse || dec_pulse) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, inc_pulse, dec_pulse}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_dir", inc_pulse, e.up);
          chk("pulse_duty", duty, e.duty);
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("missing_pulse", 0, 1);
      end
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(bit i, bit d, int ticks);
    inc_btn = i; dec_btn = d;
    wait_cyc(ticks * TD);
    inc_btn = 1'b0; dec_btn = 1'b0;
    wait_cyc(3 * TD);
  endtask

  // reset edges are placed off the negedge so the monitor never races them
  task automatic do_reset();
    @(negedge clk); #2 rst = 1'b1;
    wait_cyc(2);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    wait_cyc(3);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_duty", duty, DRST);

    // single long press
    press(1'b1, 1'b0, 22);
`ifdef PWM_DUTY_AUTOREPEAT_EN
    chk("long_press_duty", duty, 9);
`else
    chk("long_press_duty", duty, 6);
`endif

    // glitch covering exactly one tick sample
    do_reset();
    inc_btn = 1'b1; wait_cyc(TD); inc_btn = 1'b0;
    wait_cyc(5 * TD);
    chk("glitch_duty", duty, DRST);

    // saturation both ways
    for (int k = 0; k < 5; k++) press(1'b1, 1'b0, 3);
    chk("sat_max_duty", duty, DMAX);
    chk("sat_at_max", at_max, 1);
    for (int k = 0; k < 9; k++) press(1'b0, 1'b1, 3);
    chk("sat_min_duty", duty, DMIN);
    chk("sat_at_min", at_min, 1);

    // simultaneous press -> lock, partial release keeps lock
    do_reset();
    inc_btn = 1'b1; dec_btn = 1'b1; wait_cyc(4 * TD);
    dec_btn = 1'b0; wait_cyc(4 * TD);
    chk("lock_duty", duty, DRST);
    inc_btn = 1'b0; wait_cyc(3 * TD);
    press(1'b0, 1'b1, 3);
    chk("after_lock_dec", duty, DRST - 1);

    // async reset mid-hold at duty 7
    do_reset();
    press(1'b1, 1'b0, 3);
    inc_btn = 1'b1; wait_cyc(4 * TD);
    chk("pre_reset_duty", duty, 7);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_duty", duty, DRST);
    chk("async_rst_pulses", {30'd0, inc_pulse, dec_pulse}, 0);
    inc_btn = 1'b0;
    wait_cyc(2);
    #2 rst = 1'b0;
    wait_cyc(6 * TD);
    chk("post_reset_idle", duty, DRST);
    press(1'b1, 1'b0, 3);
    chk("post_reset_press", duty, DRST + 1);

    // randomized patterns against the model
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        do_reset();
      end else begin
        inc_btn = 1'($urandom_range(0, 1));
        dec_btn = 1'($urandom_range(0, 1));
        wait_cyc($urandom_range(1, 8 * TD));
      end
    end
    inc_btn = 1'b0; dec_btn = 1'b0;
    wait_cyc(5 * TD);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
